// File: rtl/rca1_adder.sv
// Registered ripple-carry adder with an optional ones'-complement subtract path.
// Subtract path compiled in with `define RCA1_SUB_EN.
module rca1_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef RCA1_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   c1;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] sum;

`ifdef RCA1_SUB_EN
  assign b_op  = sub ? ~B : B;
  assign c1[0] = sub ? 1'b0 : cin;
`else
  assign b_op  = B;
  assign c1[0] = cin;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa1
    assign y[i]    = A[i] ^ b_op[i] ^ c1[i];
    assign c1[i+1] = (A[i] & b_op[i]) | (A[i] & c1[i]) |
                     (b_op[i] & c1[i]);
  end

`ifdef RCA1_SUB_EN
  // End-around carry rippled back in; carry out of this chain is dropped.
  logic [WIDTH-1:0] c2;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] zero;

  assign zero  = '0;
  assign c2[0] = sub & c1[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa2
    assign s2[i] = y[i] ^ zero[i] ^ c2[i];
    if (i < WIDTH-1) begin : g_c
      assign c2[i+1] = (y[i] & zero[i]) | (y[i] & c2[i]) |
                       (zero[i] & c2[i]);
    end
  end

  assign sum = s2;
`else
  assign sum = y;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      S         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sum;
        cout <= c1[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_rca1_adder.sv
// Scoreboard bench for rca1_adder (WIDTH=4).
// Subtract scenarios run when RCA1_SUB_EN is defined.
module tb_rca1_adder;

  typedef struct packed {
    logic       c;
    logic [3:0] s;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
`ifdef RCA1_SUB_EN
  logic       sub;
`endif
  logic [3:0] s;
  logic       cout;
  logic       out_valid;

  exp_t q[$];
  exp_t e;
  int   nvec;
  int   nerr;

  rca1_adder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .cin       (cin),
`ifdef RCA1_SUB_EN
    .sub       (sub),
`endif
    .S         (s),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] x,
                                 input logic [3:0] y,
                                 input logic c,
                                 input logic sb);
    exp_t r;
    int   t;
    if (!sb) begin
      t   = int'(x) + int'(y) + int'(c);
      r.s = t[3:0];
      r.c = t[4];
    end else if (x > y) begin
      r.c = 1'b1;
      r.s = x - y;
    end else begin
      r.c = 1'b0;
      r.s = ~(y - x);
    end
    return r;
  endfunction

  // Drive one valid op and push its expected result.
  task automatic push_op(input logic [3:0] x, input logic [3:0] y,
                         input logic c, input logic sb);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
`ifdef RCA1_SUB_EN
    sub      = sb;
`endif
    q.push_back(model(x, y, c, sb));
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 4'hF;
    b        = 4'hF;
    cin      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      nvec++;
      if ({out_valid, cout, s} !== 6'b0) begin
        nerr++;
        $display("FAIL reset[%0d]: got v=%b c=%b s=%h want 0/0/0",
                 i, out_valid, cout, s);
      end
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap;
    push_op(4'hF, 4'h1, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = q.pop_front();
    nvec++;
    if ({out_valid, cout, s} !== {1'b1, 1'b1, 4'h0} ||
        e !== {1'b1, 4'h0}) begin
      nerr++;
      $display("FAIL add_wrap: got v=%b c=%b s=%h want 1/1/0",
               out_valid, cout, s);
    end
    push_op(4'h3, 4'h4, 1'b1, 1'b0);
    @(posedge clk); #1;
    e = q.pop_front();
    nvec++;
    if ({out_valid, cout, s} !== {1'b1, 1'b0, 4'h8}) begin
      nerr++;
      $display("FAIL add_cin: got v=%b c=%b s=%h want 1/0/8",
               out_valid, cout, s);
    end
  endtask

`ifdef RCA1_SUB_EN
  task automatic test_sub;
    logic [3:0] xs[3];
    logic [3:0] ys[3];
    logic [4:0] want[3];
    xs   = '{4'd5, 4'd3, 4'd7};
    ys   = '{4'd3, 4'd5, 4'd7};
    want = '{5'h12, 5'h0D, 5'h0F};
    for (int i = 0; i < 3; i++) begin
      push_op(xs[i], ys[i], 1'b1, 1'b1);
      @(posedge clk); #1;
      e = q.pop_front();
      nvec++;
      if (!out_valid || {cout, s} !== want[i]) begin
        nerr++;
        $display("FAIL sub[%0d]: got v=%b c=%b s=%h want c/s=%h",
                 i, out_valid, cout, s, want[i]);
      end
    end
    sub = 1'b0;
  endtask
`endif

  task automatic test_streaming;
    logic [3:0] last_s;
    logic       last_c;
    push_op(4'h2, 4'h9, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      nvec++;
      if (!out_valid || {cout, s} !== e) begin
        nerr++;
        $display("FAIL stream[%0d]: got v=%b c/s=%h want 1/%h",
                 i, out_valid, {cout, s}, e);
      end
      if (i == 0) push_op(4'hA, 4'h7, 1'b1, 1'b0);
      if (i == 1) push_op(4'h6, 4'h6, 1'b0, 1'b0);
      if (i == 2) in_valid = 1'b0;
    end
    last_s = e.s;
    last_c = e.c;
    @(posedge clk); #1;
    nvec++;
    if (out_valid !== 1'b0 || s !== last_s || cout !== last_c) begin
      nerr++;
      $display("FAIL stream_hold: got v=%b c=%b s=%h want 0/%b/%h",
               out_valid, cout, s, last_c, last_s);
    end
  endtask

  task automatic test_reset_mid;
    push_op(4'h5, 4'h5, 1'b0, 1'b0);
    rst = 1'b1;
    void'(q.pop_back());
    @(posedge clk); #1;
    nvec++;
    if ({out_valid, cout, s} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_mid: got v=%b c=%b s=%h want 0/0/0",
               out_valid, cout, s);
    end
    rst = 1'b0;
    push_op(4'hC, 4'h5, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = q.pop_front();
    nvec++;
    if (!out_valid || {cout, s} !== e) begin
      nerr++;
      $display("FAIL post_reset: got v=%b c/s=%h want 1/%h",
               out_valid, {cout, s}, e);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive;
    int nsb;
`ifdef RCA1_SUB_EN
    nsb = 2;
`else
    nsb = 1;
`endif
    for (int m = 0; m < nsb; m++) begin
      for (int i = 0; i < 512; i++) begin
        logic [8:0] v;
        v = 9'(i);
        if (m == 1 && v[8]) continue;
        push_op(v[3:0], v[7:4],
                (m == 1) ? 1'($urandom_range(0, 1)) : v[8],
                1'(m));
        @(posedge clk); #1;
        e = q.pop_front();
        nvec++;
        if (!out_valid || {cout, s} !== e) begin
          nerr++;
          $display("FAIL exh m=%0d a=%h b=%h: got v=%b c/s=%h want %h",
                   m, v[3:0], v[7:4], out_valid, {cout, s}, e);
        end
      end
    end
    in_valid = 1'b0;
`ifdef RCA1_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
`ifdef RCA1_SUB_EN
    sub      = 1'b0;
`endif
    #1;
    test_reset();
    test_add_wrap();
`ifdef RCA1_SUB_EN
    test_sub();
`endif
    test_streaming();
    test_reset_mid();
    test_exhaustive();
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rca1_adder.md
# rca1_adder

Registered WIDTH-bit ripple-carry adder built from a chain of 1-bit full adders, plus a bitwise inverter stage on operand B. It is the arithmetic leaf used by the logic-gate datapath. It adds two unsigned operands with carry-in. When the optional subtract feature is compiled in, it also computes A−B in ones'-complement form with end-around carry.

## Interface
Parameters:
- WIDTH, default 4: operand and sum width in bits; must be at least 1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operands are presented this cycle.
- A, input, WIDTH: operand A, unsigned.
- B, input, WIDTH: operand B, unsigned.
- cin, input, 1: carry-in into bit 0 (add mode only).
- sub, input, 1: selects subtract mode; this port exists only when RCA1_SUB_EN is defined.
- S, output, WIDTH: registered sum or difference.
- cout, output, 1: registered carry-out (add mode) or end-around carry (subtract mode).
- out_valid, output, 1: S and cout hold a fresh result.

## Operation
- **Ripple chain:** bit i computes s_i = a_i ^ b_i ^ c_i and c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i. The carry c_0 feeds bit 0, and c_WIDTH is the carry-out.
- **Add mode** (sub=0, or feature compiled out):
  - {cout, S} = A + B + cin, exact (WIDTH+1)-bit result.
  - Wrap-around at 2^WIDTH appears only through cout.
- **Subtract mode** (sub=1):
  - B is inverted bitwise (NOT stage) and cin is ignored.
  - Stage 1: {c, Y} = A + ~B + 0.
  - Stage 2: S = (Y + c) mod 2^WIDTH, i.e. the end-around carry is added back through a second ripple chain with a zero second operand.
  - cout = c: 1 means A > B, and S = A−B.
  - cout = 0 means A ≤ B, and S = ~(B−A), the ones'-complement encoding of a negative value.
  - A==B yields S = all ones ("negative zero") with cout=0.
- Purely combinational between the input sampling point and the output register. There is no internal state besides the output register.

## Timing
- **Latency:** exactly 1 cycle. Operands sampled at edge k with in_valid=1 appear on S/cout at edge k, visible in cycle k+1, with out_valid=1.
- **in_valid=0:** out_valid deasserts at the next edge. S and cout hold their previous values.
- **Throughput:** one operation per cycle; back-to-back in_valid is fully supported.
- **No backpressure:** a new result overwrites the previous one.
- **Reset:** while rst=1 at an edge, S=0, cout=0 and out_valid=0, regardless of in_valid. Reset has priority over a simultaneous valid input.
- **Reset mid-stream:** the in-flight result is discarded. The first valid operands after rst deasserts produce output one cycle later.

## Configuration
- Macro RCA1_SUB_EN.
- **Defined:** the sub port, NOT stage, and end-around-carry second chain are present, and subtract mode behaves as above.
- **Undefined:** the block is a plain registered adder. There is no sub port, and the inverter and second chain are not instantiated.

## Test plan
- **Reset:** hold rst=1 for 2 cycles with in_valid=1, A=4'hF, B=4'hF. Required: S=0, cout=0, out_valid=0 throughout.
- **Add with wrap:** A=4'hF, B=4'h1, cin=0. Next cycle: S=4'h0, cout=1, out_valid=1. Then A=4'h3, B=4'h4, cin=1 gives S=4'h8, cout=0.
- **Subtract, positive (RCA1_SUB_EN):** A=5, B=3, sub=1, cin=1. Required: S=4'h2, cout=1; cin is ignored.
- **Subtract, negative and zero:** A=3, B=5, sub=1 gives S=4'hD (~2), cout=0. A=7, B=7 gives S=4'hF, cout=0.
- **Streaming:** 3 back-to-back valid add ops, then in_valid=0. Required: results in order at 1-cycle latency, out_valid then drops while S holds the last value.
- **Exhaustive:** all 512 add combinations of A, B, cin (WIDTH=4), plus all 256 subtract combinations when enabled. Check against a reference model.
